// File: rtl/fc_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_seq_if
// Brief    : Handshake and memory-read bundle for the fc_mac_seq neuron
//            sequencer. The slave modport is the sequencer's view; the
//            master modport is the view of whoever issues start/bias and
//            owns the node/weight memories.
// Revision : 1.0 - initial release
// ============================================================================
interface fc_mac_seq_if #(
  parameter int AW = 4
);
  logic                 start;
  logic signed [7:0]    bias;
  logic                 busy;
  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [7:0]    node_data;
  logic signed [7:0]    wegt_data;
  logic signed [7:0]    result;
  logic                 done;

  modport slave (
    input  start, bias, node_data, wegt_data,
    output busy, rd_en, rd_addr, result, done
  );

  modport master (
    output start, bias, node_data, wegt_data,
    input  busy, rd_en, rd_addr, result, done
  );
endinterface
`default_nettype wire

// File: rtl/fc_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_seq
// Brief    : Evaluates one fully-connected neuron: streams N_IN node/weight
//            pairs from two shared-address synchronous-read memories,
//            accumulates the signed 8x8 products, adds bias, arithmetic
//            right shift by SHIFT and saturates to a signed 8-bit result.
//            Optional build macro FC_RELU_EN clamps negative results to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fc_mac_seq #(
  parameter int N_IN  = 16,
  parameter int AW    = 4,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input wire          clk,
  input wire          rst,
  fc_mac_seq_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_FINAL = 2'd3;

  localparam logic [AW-1:0]           c_LAST    = AW'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-128);

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [AW-1:0]            r_cnt;
  logic                     r_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [7:0]        r_bias;
  logic signed [7:0]        r_result;
  logic                     r_done;

  logic                     w_rd_en;
  logic                     w_busy;
  logic                     w_accept;
  logic                     w_final;
  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_scaled;
  logic signed [7:0]        w_sat;

  // Product of the pair returned by the memories, widened to the accumulator
  assign w_prod     = bus.node_data * bus.wegt_data;
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; start is only looked at in IDLE so requests while busy are dropped
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_next_state = c_RUN;
      c_RUN:   if (r_cnt == c_LAST) w_next_state = c_DRAIN;
      c_DRAIN: w_next_state = c_FINAL;
      c_FINAL: w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    w_rd_en  = 1'b0;
    w_busy   = 1'b0;
    w_accept = 1'b0;
    w_final  = 1'b0;
    case (r_state)
      c_IDLE:  w_accept = bus.start;
      c_RUN:   begin w_rd_en = 1'b1; w_busy = 1'b1; end
      c_DRAIN: w_busy = 1'b1;
      c_FINAL: begin w_busy = 1'b1; w_final = 1'b1; end
      default: ;
    endcase
  end

  // Read address counter; wraps back to 0 on the last read so rd_addr idles at 0
  always_ff @(posedge clk) begin
    if (rst)                         r_cnt <= '0;
    else if (w_accept)               r_cnt <= '0;
    else if (w_rd_en) begin
      if (r_cnt == c_LAST)           r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
    end
  end

  // Accumulate pipe: vld tracks the 1-cycle memory latency; bias captured at accept only
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_acc  <= '0;
      r_bias <= '0;
    end else begin
      r_vld <= w_rd_en;
      if (w_accept) begin
        r_acc  <= '0;
        r_bias <= bus.bias;
      end else if (r_vld) begin
        r_acc  <= r_acc + w_prod_ext;
      end
    end
  end

  // Bias add, arithmetic scale and saturation to signed 8 bits
  always_comb begin
    w_sum    = r_acc + {{(ACC_W-8){r_bias[7]}}, r_bias};
    w_scaled = w_sum >>> SHIFT;
    if (w_scaled > c_SAT_MAX)      w_sat = 8'sh7F;
    else if (w_scaled < c_SAT_MIN) w_sat = 8'sh80;
    else                           w_sat = w_scaled[7:0];
`ifdef FC_RELU_EN
    if (w_sat[7]) w_sat = 8'sh00;
`else
    w_sat = w_sat;
`endif
  end

  // Result register and done pulse, both launched from FINAL
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_final) r_result <= w_sat;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.rd_en   = w_rd_en;
  assign bus.rd_addr = r_cnt;
  assign bus.result  = r_result;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_mac_seq
// Brief    : Self-checking bench for fc_mac_seq (N_IN=4). Two instances share
//            stimulus, one with SHIFT=0 and one with SHIFT=7; expected values
//            come from a plain-arithmetic neuron model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_mac_seq;
  localparam int N = 4;
`ifdef FC_RELU_EN
  localparam bit c_RELU = 1'b1;
`else
  localparam bit c_RELU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   nodes[N];
  int   wegts[N];

  fc_mac_seq_if #(.AW(2)) bus0 ();
  fc_mac_seq_if #(.AW(2)) bus7 ();

  fc_mac_seq #(.N_IN(N), .AW(2), .ACC_W(24), .SHIFT(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fc_mac_seq #(.N_IN(N), .AW(2), .ACC_W(24), .SHIFT(7)) u_dut7 (
    .clk (clk),
    .rst (rst),
    .bus (bus7)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read node/weight memories, one-cycle latency
  always @(posedge clk) begin
    if (bus0.rd_en) begin
      bus0.node_data <= 8'(nodes[bus0.rd_addr]);
      bus0.wegt_data <= 8'(wegts[bus0.rd_addr]);
    end
    if (bus7.rd_en) begin
      bus7.node_data <= 8'(nodes[bus7.rd_addr]);
      bus7.wegt_data <= 8'(wegts[bus7.rd_addr]);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference neuron: dot product plus bias, shift, clamp, optional relu
  function automatic int model(input int shift, input int b);
    int s;
    s = b;
    for (int i = 0; i < N; i++) s += nodes[i] * wegts[i];
    s = s >>> shift;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (c_RELU && s < 0) s = 0;
    return s;
  endfunction

  task automatic drive_start(input bit v);
    bus0.start = v;
    bus7.start = v;
  endtask

  task automatic drive_bias(input int b);
    bus0.bias = 8'(b);
    bus7.bias = 8'(b);
  endtask

  function automatic int rand8();
    return int'($urandom_range(255)) - 128;
  endfunction

  // One evaluation, checked cycle by cycle. Cycle 0 is the accept cycle.
  // chained: the accept cycle was the previous run's done cycle (already sampled).
  task automatic run(input string tag, input int b, input bit chained, input int b_late,
                     input bit spur, input bit hold_next, input int next_b, input int rst_at);
    int  e0, e7, last;
    bit  rs, exp_rd;
    e0   = model(0, b);
    e7   = model(7, b);
    last = hold_next ? N + 3 : N + 4;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        if (!chained) begin
          @(posedge clk); #1;
          drive_start(1'b1);
          drive_bias(b);
        end
      end else begin
        @(posedge clk); #1;
        drive_start((spur && (c == 2 || c == 3)) || (hold_next && c == N + 3));
        if (c == 2) drive_bias(b_late);
        if (hold_next && c == N + 3) drive_bias(next_b);
        rst = (c == rst_at);
      end
      if (!(c == 0 && chained)) begin
        @(negedge clk);
        rs     = (rst_at >= 0) && (c > rst_at);
        exp_rd = !rs && c >= 1 && c <= N;
        check($sformatf("%s c%0d rd_en", tag, c), int'(bus0.rd_en), int'(exp_rd));
        if (exp_rd)
          check($sformatf("%s c%0d rd_addr", tag, c), int'(bus0.rd_addr), c - 1);
        check($sformatf("%s c%0d busy", tag, c), int'(bus0.busy),
              int'(!rs && c >= 1 && c <= N + 2));
        check($sformatf("%s c%0d done0", tag, c), int'(bus0.done), int'(!rs && c == N + 3));
        check($sformatf("%s c%0d done7", tag, c), int'(bus7.done), int'(!rs && c == N + 3));
        if (rs) begin
          check($sformatf("%s c%0d rst_result0", tag, c), int'(bus0.result), 0);
          check($sformatf("%s c%0d rst_result7", tag, c), int'(bus7.result), 0);
        end else if (c >= N + 3) begin
          check($sformatf("%s c%0d result0", tag, c), int'(bus0.result), e0);
          check($sformatf("%s c%0d result7", tag, c), int'(bus7.result), e7);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    int  b, nb;
    bit  chain, hn;
    drive_start(1'b0);
    drive_bias(0);
    nodes = '{0, 0, 0, 0};
    wegts = '{0, 0, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",    int'(bus0.busy),    0);
    check("reset rd_en",   int'(bus0.rd_en),   0);
    check("reset rd_addr", int'(bus0.rd_addr), 0);
    check("reset result",  int'(bus0.result),  0);
    check("reset done",    int'(bus0.done),    0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic dot product, timing
    nodes = '{1, 2, 3, 4};
    wegts = '{1, 1, 1, 1};
    run("t1", 0, 1'b0, 0, 1'b0, 1'b0, 0, -1);
    check("t1 literal", int'(bus0.result), 10);

    // 2: positive saturation
    nodes = '{127, 127, 127, 127};
    wegts = '{127, 127, 127, 127};
    run("t2", 0, 1'b0, 0, 1'b0, 1'b0, 0, -1);
    check("t2 literal", int'(bus7.result), 127);

    // 3: negative saturation (or relu clamp)
    nodes = '{-128, -128, -128, -128};
    run("t3", 0, 1'b0, 0, 1'b0, 1'b0, 0, -1);
    check("t3 literal", int'(bus7.result), c_RELU ? 0 : -128);

    // 4: bias only; late bias change has no effect
    nodes = '{0, 0, 0, 0};
    wegts = '{0, 0, 0, 0};
    run("t4", -5, 1'b0, 9, 1'b0, 1'b0, 0, -1);
    check("t4 literal", int'(bus0.result), c_RELU ? 0 : -5);

    // 5: spurious starts ignored; start held in done cycle chains a second run
    nodes = '{1, 2, 3, 4};
    wegts = '{1, 1, 1, 1};
    run("t5a", 0, 1'b0, 0, 1'b1, 1'b1, 3, -1);
    run("t5b", 3, 1'b1, 3, 1'b0, 1'b0, 0, -1);
    check("t5 literal", int'(bus0.result), 13);

    // 6: reset in cycle 3 aborts and clears result, restart completes
    nodes = '{5, 5, 5, 5};
    wegts = '{2, 3, 4, 5};
    run("t6a", 0, 1'b0, 0, 1'b0, 1'b0, 0, 3);
    run("t6b", 1, 1'b0, 1, 1'b0, 1'b0, 0, -1);
    check("t6 literal", int'(bus0.result), 71);

    // Randomized evaluations, some chained back-to-back
    chain = 1'b0;
    b     = rand8();
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < N; k++) begin
        nodes[k] = rand8();
        wegts[k] = rand8();
      end
      hn = (i < 23) ? 1'($urandom_range(1)) : 1'b0;
      nb = rand8();
      run($sformatf("rnd%0d", i), b, chain, rand8(), 1'($urandom_range(1)), hn, nb, -1);
      chain = hn;
      b     = nb;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
